// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared 4:1 mux. Drives sel/gnt and registers dout for the owner.
// Optional per-owner hold limit is built in when ARB_TIMEOUT_EN is defined.
module mux_rr_arbiter #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] req,
   input  logic [3:0] din,
   output logic [1:0] sel,
   output logic [3:0] gnt,
   output logic       busy,
   output logic       dout,
   output logic       timeout
);

   // state   | meaning
   // IDLE    | no owner, arbitrate on req starting at ptr
   // GRANT   | requester sel owns the mux, dout follows din[sel]
   // RELEASE | one dead turnaround cycle, req ignored
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_GRANT   = 2'd1;
   localparam logic [1:0] ST_RELEASE = 2'd2;

   logic [1:0] state;
   logic [1:0] ptr;
   logic [1:0] win;
   logic [1:0] idx;
   logic       found;
   logic       limit_hit;

   // First requester at or after ptr, wrapping mod 4.
   always_comb begin
      win   = ptr;
      idx   = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && req[idx]) begin
            win   = idx;
            found = 1'b1;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // Held at zero outside GRANT so every new owner starts from a clean count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (state == ST_GRANT) begin
         cnt <= cnt + CNT_W'(1);
      end else begin
         cnt <= '0;
      end
   end

   assign limit_hit = (cnt == CNT_LIMIT);
`else
   logic cfg_unused;

   assign cfg_unused = (TIMEOUT_CYCLES >= 2) && (CNT_W > 0);
   assign limit_hit  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         ptr     <= 2'd0;
         sel     <= 2'd0;
         gnt     <= 4'd0;
         busy    <= 1'b0;
         dout    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         timeout <= 1'b0;
         case (state)
            ST_IDLE: begin
               dout <= 1'b0;
               if (found) begin
                  sel   <= win;
                  gnt   <= 4'b0001 << win;
                  busy  <= 1'b1;
                  state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!req[sel] || limit_hit) begin
                  gnt     <= 4'd0;
                  busy    <= 1'b0;
                  dout    <= 1'b0;
                  ptr     <= sel + 2'd1;
                  timeout <= req[sel];
                  state   <= ST_RELEASE;
               end else begin
                  dout <= din[sel];
               end
            end
            ST_RELEASE: begin
               state <= ST_IDLE;
            end
            default: begin
               gnt   <= 4'd0;
               busy  <= 1'b0;
               dout  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed self-checking bench for mux_rr_arbiter; hold-limit scenarios follow ARB_TIMEOUT_EN.
module tb_mux_rr_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] req;
   logic [3:0] din;
   logic [1:0] sel;
   logic [3:0] gnt;
   logic       busy;
   logic       dout;
   logic       timeout;

   int n_cmp;
   int n_bad;

   mux_rr_arbiter #(.TIMEOUT_CYCLES(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .din     (din),
      .sel     (sel),
      .gnt     (gnt),
      .busy    (busy),
      .dout    (dout),
      .timeout (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 time unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req   = 4'b1111;
      din   = 4'b1111;
      repeat (3) step();
      n_cmp++;
      if ({sel, gnt, busy, dout, timeout} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_hold: got sel=%0d gnt=%b busy=%b dout=%b to=%b want all zero", sel, gnt, busy, dout, timeout);
      end
      rst_n = 1'b1;
      req   = 4'b0000;
      din   = 4'b0000;
      step();
      req = 4'b0001;
      step();
      n_cmp++;
      if (gnt !== 4'b0001 || busy !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_grant: got gnt=%b busy=%b want 0001 1", gnt, busy);
      end
      din = 4'b0001;
      step();
      n_cmp++;
      if (dout !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_pre_dout: got %b want 1", dout);
      end
      #3 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({sel, gnt, busy, dout, timeout} !== 9'b0) begin
         n_bad++;
         $display("FAIL reset_async: got sel=%0d gnt=%b busy=%b dout=%b to=%b want all zero", sel, gnt, busy, dout, timeout);
      end
      req = 4'b0000;
      din = 4'b0000;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      req = 4'b0100;
      din = 4'b0100;
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1 || dout !== 1'b0) begin
         n_bad++;
         $display("FAIL single_grant: got gnt=%b sel=%0d busy=%b dout=%b want 0100 2 1 0", gnt, sel, busy, dout);
      end
      step();
      n_cmp++;
      if (dout !== 1'b1) begin
         n_bad++;
         $display("FAIL single_dout: got %b want 1", dout);
      end
      req = 4'b0000;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || dout !== 1'b0 || sel !== 2'd2) begin
         n_bad++;
         $display("FAIL single_release: got gnt=%b busy=%b dout=%b sel=%0d want 0000 0 0 2", gnt, busy, dout, sel);
      end
      req = 4'b1000;
      step();
      n_cmp++;
      if (gnt !== 4'b0000) begin
         n_bad++;
         $display("FAIL single_dead_cycle: got gnt=%b want 0000", gnt);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b1000 || sel !== 2'd3) begin
         n_bad++;
         $display("FAIL single_regrant: got gnt=%b sel=%0d want 1000 3", gnt, sel);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_fairness();
      logic [1:0] o;
      logic [3:0] oh;
      req = 4'b1111;
      din = 4'b0000;
      step();
      for (int n = 0; n < 5; n++) begin
         o  = 2'(n);
         oh = 4'b0001 << o;
         n_cmp++;
         if (gnt !== oh || sel !== o || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_grant_%0d: got gnt=%b sel=%0d busy=%b want %b %0d 1", n, gnt, sel, busy, oh, o);
         end
         din = oh;
         step();
         n_cmp++;
         if (dout !== 1'b1) begin
            n_bad++;
            $display("FAIL rr_dout_hi_%0d: got %b want 1", n, dout);
         end
         din = ~oh;
         step();
         n_cmp++;
         if (dout !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_dout_lo_%0d: got %b want 0", n, dout);
         end
         req = req & ~oh;
         step();
         n_cmp++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL rr_release_%0d: got gnt=%b busy=%b want 0000 0", n, gnt, busy);
         end
         req = (n < 4) ? 4'b1111 : 4'b0000;
         step();
         n_cmp++;
         if (gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL rr_spacing_%0d: got gnt=%b want 0000", n, gnt);
         end
         if (n < 4) step();
      end
      din = 4'b0000;
   endtask

   task automatic test_wrap();
      req = 4'b0100;
      step();
      n_cmp++;
      if (gnt !== 4'b0100) begin
         n_bad++;
         $display("FAIL wrap_owner2: got gnt=%b want 0100", gnt);
      end
      req = 4'b0000;
      step();
      req = 4'b0011;
      step();
      step();
      n_cmp++;
      if (gnt !== 4'b0001 || sel !== 2'd0) begin
         n_bad++;
         $display("FAIL wrap_grant: got gnt=%b sel=%0d want 0001 0", gnt, sel);
      end
      req = 4'b0000;
      step();
      step();
   endtask

   task automatic test_timeout();
      req = 4'b0110;
      step();
      n_cmp++;
      if (gnt !== 4'b0010 || sel !== 2'd1) begin
         n_bad++;
         $display("FAIL to_first_grant: got gnt=%b sel=%0d want 0010 1", gnt, sel);
      end
`ifdef ARB_TIMEOUT_EN
      for (int i = 2; i <= 4; i++) begin
         step();
         n_cmp++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL to_hold_cycle%0d: got gnt=%b to=%b want 0010 0", i, gnt, timeout);
         end
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b1) begin
         n_bad++;
         $display("FAIL to_forced_release: got gnt=%b busy=%b to=%b want 0000 0 1", gnt, busy, timeout);
      end
      step();
      n_cmp++;
      if (timeout !== 1'b0 || gnt !== 4'b0000) begin
         n_bad++;
         $display("FAIL to_pulse_width: got to=%b gnt=%b want 0 0000", timeout, gnt);
      end
      step();
      n_cmp++;
      if (gnt !== 4'b0100 || sel !== 2'd2) begin
         n_bad++;
         $display("FAIL to_next_owner: got gnt=%b sel=%0d want 0100 2", gnt, sel);
      end
`else
      for (int i = 0; i < 120; i++) begin
         step();
         n_cmp++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL to_off_hold_%0d: got gnt=%b to=%b want 0010 0", i, gnt, timeout);
         end
      end
`endif
      req = 4'b0000;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL to_normal_release: got gnt=%b to=%b want 0000 0", gnt, timeout);
      end
      step();
   endtask

   task automatic test_limit_drop();
      req = 4'b0010;
      step();
      for (int i = 1; i <= 4; i++) begin
         n_cmp++;
         if (gnt !== 4'b0010 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL drop_hold_cycle%0d: got gnt=%b to=%b want 0010 0", i, gnt, timeout);
         end
         if (i < 4) step();
      end
      req = 4'b0000;
      step();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_release: got gnt=%b busy=%b to=%b want 0000 0 0", gnt, busy, timeout);
      end
      step();
      n_cmp++;
      if (timeout !== 1'b0) begin
         n_bad++;
         $display("FAIL drop_no_pulse: got to=%b want 0", timeout);
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst_n = 1'b0;
      req   = 4'b0000;
      din   = 4'b0000;
      test_reset();
      test_single();
      test_fairness();
      test_wrap();
      test_timeout();
      test_limit_drop();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
